sobel_stream: RTL and testbench

Streaming, parametrised 3×3 Sobel edge detector between the camera-frame BRAM (RGB444) and the edge BRAM. After `start`, it reads every source pixel once in raster order at one address per clock and holds the last two rows in internal line buffers. It writes one edge value per interior pixel, either a thresholded bit or a scaled gradient magnitude. It supersedes the nine-reads-per-pixel sobel: throughput is one pixel per clock, and frame size, border, BRAM latency and output mode are configurable.

---
 rtl/sobel_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_sobel_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: RGB444 source BRAM in raster order -> one edge value per interior pixel.
// Latency: pixel address driven in cycle t -> its centre write presented in cycle t+RD_LAT+4.
// Backpressure: none; one read per clock while scanning, the edge BRAM must accept every write.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   start, mode, threshold   frame request (IDLE only); mode/threshold latched at accept
//   busy, done               frame in progress / one-cycle completion pulse
//   pixel_data, pic_memory_addr               source BRAM read side
//   edge_data, edge_memory_addr, edge_we      edge BRAM write side
module sobel_stream #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CH_W   = 4,
  parameter int ADDR_W = 19,
  parameter int BORDER = 25,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [CH_W+2:0]     threshold,
  output logic                busy,
  output logic                done,
  input  logic [3*CH_W-1:0]   pixel_data,
  output logic [ADDR_W-1:0]   pic_memory_addr,
  output logic [CH_W-1:0]     edge_data,
  output logic [ADDR_W-1:0]   edge_memory_addr,
  output logic                edge_we
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int GW = CH_W + 4;            // signed gradient width
  localparam int MW = CH_W + 3;            // unsigned magnitude width
  localparam int DW = $clog2(RD_LAT + 4) + 1;
  localparam logic [XW-1:0]     X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(HEIGHT - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT + 3);
  // The window completes at (x,y); its centre sits one row up and one column left.
  localparam logic [ADDR_W-1:0] CTR_OFS    = ADDR_W'(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              accept, issue, scan_last;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [DW-1:0]     drain_q;
  logic              mode_q;
  logic [MW-1:0]     thr_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (scan_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    issue  = (state_q == S_SCAN);
    accept = (state_q == S_IDLE) && start;
  end

  // ---------------- raster address generation ----------------
  assign scan_last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q             <= '0;
      y_q             <= '0;
      pic_memory_addr <= '0;
      drain_q         <= '0;
      mode_q          <= 1'b0;
      thr_q           <= '0;
    end else begin
      if (accept) begin
        x_q             <= '0;
        y_q             <= '0;
        pic_memory_addr <= '0;
        mode_q          <= mode;
        thr_q           <= threshold;
      end else if (issue && !scan_last) begin
        pic_memory_addr <= pic_memory_addr + ADDR_W'(1);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      drain_q <= (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
    end
  end

  // ---------------- read-latency tag pipe ----------------
  // Each issued address carries its x/y/address so the returning pixel knows where it belongs.
  logic              tag_vld [RD_LAT];
  logic [XW-1:0]     tag_x   [RD_LAT];
  logic [YW-1:0]     tag_y   [RD_LAT];
  logic [ADDR_W-1:0] tag_a   [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_vld[i] <= 1'b0;
    end else begin
      tag_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag_vld[i] <= tag_vld[i-1];
    end
    tag_x[0] <= x_q;
    tag_y[0] <= y_q;
    tag_a[0] <= pic_memory_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_x[i] <= tag_x[i-1];
      tag_y[i] <= tag_y[i-1];
      tag_a[i] <= tag_a[i-1];
    end
  end

  logic              in_vld;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic [ADDR_W-1:0] in_a;
  logic [CH_W-1:0]   r_in, g_in, b_in, grey;

  assign in_vld = tag_vld[RD_LAT-1];
  assign in_x   = tag_x[RD_LAT-1];
  assign in_y   = tag_y[RD_LAT-1];
  assign in_a   = tag_a[RD_LAT-1];
  assign {r_in, g_in, b_in} = pixel_data;
  // Luma approximation; wraps rather than saturates.
  assign grey = (r_in >> 2) + (g_in >> 1) + (g_in >> 3) + (b_in >> 3);

  // ---------------- line buffers + 3x3 window ----------------
  // lb1 holds row y-2, lb0 row y-1; win[0..8] is p0..p8 in raster order.
  logic [CH_W-1:0]   lb0 [WIDTH];
  logic [CH_W-1:0]   lb1 [WIDTH];
  logic [CH_W-1:0]   win [9];
  logic              s1_vld;
  logic [XW-1:0]     s1_cx;
  logic [YW-1:0]     s1_cy;
  logic [ADDR_W-1:0] s1_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
      s1_vld <= 1'b0;
    end else begin
      // x<2 still shifts so the window refills from the new row before it is used.
      s1_vld <= in_vld && (in_x >= XW'(2)) && (in_y >= YW'(2));
      if (in_vld) begin
        win[0]    <= win[1];  win[1] <= win[2];  win[2] <= lb1[in_x];
        win[3]    <= win[4];  win[4] <= win[5];  win[5] <= lb0[in_x];
        win[6]    <= win[7];  win[7] <= win[8];  win[8] <= grey;
        lb1[in_x] <= lb0[in_x];
        lb0[in_x] <= grey;
      end
    end
    s1_cx <= in_x - XW'(1);
    s1_cy <= in_y - YW'(1);
    s1_a  <= in_a - CTR_OFS;
  end

  // ---------------- gradients ----------------
  function automatic logic signed [GW-1:0] sx(input logic [CH_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic signed [GW-1:0] gx_q, gy_q;
  logic                 s2_vld, s2_border;
  logic [ADDR_W-1:0]    s2_a;

  always_ff @(posedge clk) begin
    if (reset) s2_vld <= 1'b0;
    else       s2_vld <= s1_vld;
    gx_q <= sx(win[0]) - sx(win[2]) + (sx(win[3]) <<< 1) - (sx(win[5]) <<< 1)
          + sx(win[6]) - sx(win[8]);
    gy_q <= sx(win[0]) + (sx(win[1]) <<< 1) + sx(win[2]) - sx(win[6])
          - (sx(win[7]) <<< 1) - sx(win[8]);
    s2_border <= (int'(s1_cx) < BORDER) || (int'(s1_cx) > WIDTH - 1 - BORDER)
              || (int'(s1_cy) < BORDER) || (int'(s1_cy) > HEIGHT - 1 - BORDER);
    s2_a <= s1_a;
  end

  // ---------------- magnitude ----------------
  // |G| < 2^MW, so negating only the low MW bits yields the exact magnitude.
  logic [MW-1:0]     ax, ay, mag_q;
  logic              s3_vld, s3_border;
  logic [ADDR_W-1:0] s3_a;

  assign ax = gx_q[GW-1] ? (~gx_q[MW-1:0]) + MW'(1) : gx_q[MW-1:0];
  assign ay = gy_q[GW-1] ? (~gy_q[MW-1:0]) + MW'(1) : gy_q[MW-1:0];

  always_ff @(posedge clk) begin
    if (reset) s3_vld <= 1'b0;
    else       s3_vld <= s2_vld;
    mag_q     <= ax + ay;
    s3_border <= s2_border;
    s3_a      <= s2_a;
  end

  // ---------------- edge BRAM write ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_we          <= 1'b0;
      edge_data        <= '0;
      edge_memory_addr <= '0;
    end else begin
      edge_we <= s3_vld;
      if (s3_vld) begin
        edge_memory_addr <= s3_a;
        if (s3_border)   edge_data <= '0;
        else if (mode_q) edge_data <= mag_q[MW-1:3];
        else             edge_data <= {{(CH_W-1){1'b0}}, (mag_q > thr_q)};
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;
  localparam int W = 8, H = 6, CW = 4, AW = 19, RL = 2;
  localparam int NPIX = W * H, NWR = (W - 2) * (H - 2);
  localparam int DONE_LAT = NPIX + RL + 5;

  logic clk = 1'b0;
  logic reset, start, mode;
  logic [CW+2:0]   threshold;
  logic [1:0]      busy, done, we;
  logic [3*CW-1:0] pdat  [2];
  logic [AW-1:0]   paddr [2];
  logic [AW-1:0]   eaddr [2];
  logic [CW-1:0]   edat  [2];

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two instances differ only in BORDER (1 and 2); they see identical stimulus.
  sobel_stream #(.WIDTH(W), .HEIGHT(H), .CH_W(CW), .ADDR_W(AW), .BORDER(1), .RD_LAT(RL)) u_b1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .threshold(threshold),
    .busy(busy[0]), .done(done[0]), .pixel_data(pdat[0]), .pic_memory_addr(paddr[0]),
    .edge_data(edat[0]), .edge_memory_addr(eaddr[0]), .edge_we(we[0]));
  sobel_stream #(.WIDTH(W), .HEIGHT(H), .CH_W(CW), .ADDR_W(AW), .BORDER(2), .RD_LAT(RL)) u_b2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .threshold(threshold),
    .busy(busy[1]), .done(done[1]), .pixel_data(pdat[1]), .pic_memory_addr(paddr[1]),
    .edge_data(edat[1]), .edge_memory_addr(eaddr[1]), .edge_we(we[1]));

  // Behavioural source BRAM, 2-cycle read latency.
  logic [11:0] frame [NPIX];
  logic [11:0] rd1 [2];
  function automatic logic [11:0] mem_rd(input logic [AW-1:0] a);
    int i;
    i = int'(a);
    return (i < NPIX) ? frame[i] : 12'h000;
  endfunction
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rd1[d]  <= mem_rd(paddr[d]);
      pdat[d] <= rd1[d];
    end
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int addr; int d0; int d1; } wr_t;
  wr_t expq [$];

  function automatic int grey_of(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    return (r / 4 + g / 2 + g / 8 + b / 8) % 16;
  endfunction
  function automatic int gpx(input int x, input int y);
    return grey_of(frame[y * W + x]);
  endfunction
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction
  function automatic int edge_val(input int cx, input int cy, input bit m, input int thr, input int bd);
    int l, r, t, b, mag;
    if (cx < bd || cx > W - 1 - bd || cy < bd || cy > H - 1 - bd) return 0;
    l = gpx(cx-1, cy-1) + 2 * gpx(cx-1, cy) + gpx(cx-1, cy+1);
    r = gpx(cx+1, cy-1) + 2 * gpx(cx+1, cy) + gpx(cx+1, cy+1);
    t = gpx(cx-1, cy-1) + 2 * gpx(cx, cy-1) + gpx(cx+1, cy-1);
    b = gpx(cx-1, cy+1) + 2 * gpx(cx, cy+1) + gpx(cx+1, cy+1);
    mag = iabs(l - r) + iabs(t - b);
    return m ? mag / 8 : ((mag > thr) ? 1 : 0);
  endfunction
  // s = start-accept cycle; pixel index i is addressed in cycle s+1+i.
  task automatic build_model(input int s, input bit m, input int thr);
    wr_t e;
    for (int cy = 1; cy < H - 1; cy++)
      for (int cx = 1; cx < W - 1; cx++) begin
        e.addr = cy * W + cx;
        e.cyc  = s + 1 + ((cy + 1) * W + cx + 1) + RL + 4;
        e.d0   = edge_val(cx, cy, m, thr, 1);
        e.d1   = edge_val(cx, cy, m, thr, 2);
        expq.push_back(e);
      end
  endtask

  // ---------------- compare process ----------------
  int   wr_count = 0, done_cnt = 0, done_cyc = 0;
  bit   done_prev = 1'b0;
  bit   ok;
  wr_t  cur;
  always @(negedge clk) begin
    if (we[0] === 1'b1 || we[1] === 1'b1) begin
      if (expq.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_write: cycle %0d addr %0d, expected no write", cyc, eaddr[0]);
      end else begin
        cur = expq.pop_front();
        wr_count++;
        ok = (we == 2'b11) && (cyc == cur.cyc) && (int'(eaddr[0]) == cur.addr) &&
             (int'(eaddr[1]) == cur.addr) && (int'(edat[0]) == cur.d0) && (int'(edat[1]) == cur.d1);
        nchk++;
        if (!ok) begin
          nerr++;
          $display("FAIL write: got we=%b cyc=%0d addr=%0d/%0d data=%0d/%0d, expected cyc=%0d addr=%0d data=%0d/%0d",
                   we, cyc, eaddr[0], eaddr[1], edat[0], edat[1], cur.cyc, cur.addr, cur.d0, cur.d1);
        end
      end
    end
    if (done[0] === 1'b1 || done[1] === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_both", int'(done), 3);
    end
    if (done_prev) chk("busy_fall", int'(busy), 0);
    done_prev = (done[0] === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  int s_cyc;
  task automatic start_frame(input bit m, input int thr);
    @(posedge clk); #1;
    start = 1'b1; mode = m; threshold = 7'(thr);
    s_cyc = cyc;
    wr_count = 0; done_cnt = 0;
    build_model(s_cyc, m, thr);
    @(posedge clk); #1;
    // Settings change right after accept must have no effect on this frame.
    start = 1'b0; mode = ~m; threshold = 7'($urandom);
    @(negedge clk);
    chk("busy_rise", int'(busy), 3);
    chk("first_addr", int'(paddr[0]), 0);
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == 0) begin
      nchk++; nerr++;
      $display("FAIL %s_done_timeout: no done after %0d cycles, expected done", tag, n);
    end else begin
      chk({tag, "_done_latency"}, done_cyc - s_cyc, DONE_LAT);
      chk({tag, "_write_count"}, wr_count, NWR);
      chk({tag, "_missing_writes"}, expq.size(), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_busy%0d", tag, d), int'(busy[d]), 0);
      chk($sformatf("%s_done%0d", tag, d), int'(done[d]), 0);
      chk($sformatf("%s_we%0d", tag, d), int'(we[d]), 0);
      chk($sformatf("%s_edata%0d", tag, d), int'(edat[d]), 0);
      chk($sformatf("%s_eaddr%0d", tag, d), int'(eaddr[d]), 0);
      chk($sformatf("%s_paddr%0d", tag, d), int'(paddr[d]), 0);
    end
  endtask

  task automatic set_step(input int black_cols);
    for (int i = 0; i < NPIX; i++) frame[i] = ((i % W) < black_cols) ? 12'h000 : 12'hFFF;
  endtask
  task automatic set_random();
    for (int i = 0; i < NPIX; i++) frame[i] = 12'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [11:0] pv;
  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; threshold = '0;
    set_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Model pins
    pv = 12'hFFF;
    chk("pin_grey_fff", grey_of(pv), 12);

    // Uniform frame, mode 0, threshold 0
    for (int i = 0; i < NPIX; i++) frame[i] = 12'hFFF;
    start_frame(1'b0, 0);
    chk("pin_uniform_size", expq.size(), NWR);
    chk("pin_uniform_first_addr", expq[0].addr, 9);
    chk("pin_uniform_row2_addr", expq[6].addr, 17);
    chk("pin_uniform_last_addr", expq[NWR-1].addr, 38);
    chk("pin_uniform_first_cyc", expq[0].cyc - s_cyc, 25);
    chk("pin_uniform_data", expq[10].d0, 0);
    finish_frame("uniform");

    // Vertical step at column 4, magnitude mode
    set_step(4);
    start_frame(1'b1, 0);
    chk("pin_step_cx3", expq[2].d0, 6);
    chk("pin_step_cx4", expq[3].d0, 6);
    chk("pin_step_cx1", expq[0].d0, 0);
    finish_frame("step_mag");

    // Strict threshold compare
    start_frame(1'b0, 47);
    chk("pin_thr47_cx3", expq[2].d0, 1);
    finish_frame("step_thr47");
    start_frame(1'b0, 48);
    chk("pin_thr48_cx3", expq[2].d0, 0);
    finish_frame("step_thr48");

    // Step at column 2: cx=1 lies inside the wider border
    set_step(2);
    start_frame(1'b1, 0);
    chk("pin_b1_cx1", expq[6].d0, 6);
    chk("pin_b2_cx1", expq[6].d1, 0);
    finish_frame("step_border");

    // start pulsed again mid-scan
    set_random();
    start_frame(1'b1, 0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_frame("restart_ignored");

    // Reset at the 20th scan cycle aborts the frame
    set_random();
    start_frame(1'b0, 20);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    check_zero("abort");
    @(posedge clk); #1 reset = 1'b0;
    done_cnt = 0;
    repeat (80) @(posedge clk);
    chk("abort_no_done", done_cnt, 0);
    start_frame(1'b1, 0);
    finish_frame("after_abort");

    // Back-to-back frames with different settings
    set_random();
    start_frame(1'b0, 30);
    finish_frame("b2b_first");
    start_frame(1'b1, 0);
    finish_frame("b2b_second");

    // Random frames and settings
    for (int k = 0; k < 4; k++) begin
      set_random();
      start_frame(1'($urandom), int'($urandom_range(0, 127)));
      finish_frame($sformatf("random%0d", k));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
